id_ex_stage: RTL and testbench

ID/EX pipeline register with load-use hazard detection for the 5-stage RV64 pipeline. It captures the decoded instruction fields, register operands, immediate and the five decode control bits (branch, mem_to_reg, mem_write, alu_src, reg_write) at the end of ID and presents them to EX. It inserts one bubble on a load-use dependency and tells IF/ID to hold. It zeroes its contents on a branch flush and keeps saturating stall/flush event counters.

---
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the 5-stage RV64 pipeline, with load-use
//   hazard detection, branch-flush squashing and saturating stall/flush
//   event counters.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_instruction        raw 32-bit instruction in ID
//   id_pc                 PC of the ID instruction
//   id_rs1_data/rs2_data  register file read data
//   id_imm                sign-extended immediate
//   id_branch .. id_reg_write   decode control bits
//   flush                 branch taken: squash the ID instruction
//   hold                  downstream stall: freeze this register
//   ex_*                  registered copies presented to EX
//   hazard_stall          combinational: hold PC and IF/ID this cycle
//   stall_count           saturating count of load-use bubbles
//   flush_count           saturating count of flushes
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instruction,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_branch,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [6:0]       ex_opcode,
  output logic             ex_branch,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Everything the register carries. The all-zero value is the bubble, so
  // the raw instruction is stored and the field outputs are sliced from it.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
    logic            branch;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
  } ex_pkt_t;

  ex_pkt_t          r_ex;
  ex_pkt_t          w_id_pkt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [6:0] w_opcode;
  logic [4:0] w_id_rs1;
  logic [4:0] w_id_rs2;
  logic [4:0] w_ex_rd;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_load_use;

  assign w_opcode = id_instruction[6:0];
  assign w_id_rs1 = id_instruction[19:15];
  assign w_id_rs2 = id_instruction[24:20];
  assign w_ex_rd  = r_ex.instr[11:7];

  // Which source registers the ID instruction actually reads. Formats with
  // no rs fields (LUI, AUIPC, JAL, ...) must never raise a false stall on
  // whatever bits happen to sit in those positions.
  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011,                       // R-type
      7'b0100011,                       // store
      7'b1100011: begin                 // branch
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      7'b0000011,                       // load
      7'b0010011: w_uses_rs1 = 1'b1;    // I-type ALU
      default: ;
    endcase
  end

  // A load in EX whose result an ID instruction needs. Stores count on rs2
  // too: store data is read in EX and there is no MEM-stage forwarding.
  // rd=x0 is hardwired zero, so a load to x0 never creates a dependency.
  assign w_load_use = id_valid & r_ex.valid & r_ex.mem_to_reg &
                      (w_ex_rd != 5'd0) &
                      ((w_uses_rs1 & (w_id_rs1 == w_ex_rd)) |
                       (w_uses_rs2 & (w_id_rs2 == w_ex_rd)));

  assign hazard_stall = (w_load_use | hold) & ~flush & ~reset;

  always_comb begin
    w_id_pkt            = '0;
    w_id_pkt.valid      = 1'b1;
    w_id_pkt.pc         = id_pc;
    w_id_pkt.rs1_data   = id_rs1_data;
    w_id_pkt.rs2_data   = id_rs2_data;
    w_id_pkt.imm        = id_imm;
    w_id_pkt.instr      = id_instruction;
    w_id_pkt.branch     = id_branch;
    w_id_pkt.mem_to_reg = id_mem_to_reg;
    w_id_pkt.mem_write  = id_mem_write;
    w_id_pkt.alu_src    = id_alu_src;
    w_id_pkt.reg_write  = id_reg_write;
  end

  // Priority: reset > flush > hold > load-use bubble > normal load.
  // The bubble carries mem_to_reg=0, so the stalled consumer sees no hazard
  // on the next cycle and the stall lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      r_ex <= '0;
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (hold) begin
      r_ex <= r_ex;
    end else if (w_load_use) begin
      r_ex <= '0;
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else if (id_valid) begin
      r_ex <= w_id_pkt;
    end else begin
      r_ex <= '0;
    end
  end

  assign ex_valid      = r_ex.valid;
  assign ex_pc         = r_ex.pc;
  assign ex_rs1_data   = r_ex.rs1_data;
  assign ex_rs2_data   = r_ex.rs2_data;
  assign ex_imm        = r_ex.imm;
  assign ex_rs1        = r_ex.instr[19:15];
  assign ex_rs2        = r_ex.instr[24:20];
  assign ex_rd         = r_ex.instr[11:7];
  assign ex_funct3     = r_ex.instr[14:12];
  assign ex_funct7     = r_ex.instr[31:25];
  assign ex_opcode     = r_ex.instr[6:0];
  assign ex_branch     = r_ex.branch;
  assign ex_mem_to_reg = r_ex.mem_to_reg;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_alu_src    = r_ex.alu_src;
  assign ex_reg_write  = r_ex.reg_write;
  assign stall_count   = r_stall_cnt;
  assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int XLEN = 64;

  // Instruction encodings
  localparam logic [31:0] ADDI5  = 32'h00700293; // addi x5,x0,7
  localparam logic [31:0] LD6    = 32'h0000B303; // ld   x6,0(x1)
  localparam logic [31:0] ADD7   = 32'h002303B3; // add  x7,x6,x2
  localparam logic [31:0] LD0    = 32'h0000B003; // ld   x0,0(x1)
  localparam logic [31:0] ADD700 = 32'h000003B3; // add  x7,x0,x0
  localparam logic [31:0] ADDI78 = 32'h00140393; // addi x7,x8,1
  localparam logic [31:0] SD6    = 32'h0060B023; // sd   x6,0(x1)
  // {branch, mem_to_reg, mem_write, alu_src, reg_write}
  localparam logic [4:0] C_LD = 5'b01011, C_R = 5'b00001, C_I = 5'b00011, C_ST = 5'b00110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, flush, hold;
  logic [31:0]     id_instruction;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic            id_branch, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;

  logic            ex_valid, ex_branch, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7, ex_opcode;
  logic            hazard_stall;
  logic [31:0]     stall_count, flush_count;

  // Narrow-counter instance sharing the same stimulus, for saturation.
  logic            s_valid, s_branch, s_m2r, s_mw, s_as, s_rw, s_hz;
  logic [XLEN-1:0] s_pc, s_d1, s_d2, s_imm;
  logic [4:0]      s_rs1, s_rs2, s_rd;
  logic [2:0]      s_f3;
  logic [6:0]      s_f7, s_op;
  logic [1:0]      s_stall, s_flush;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_opcode(ex_opcode), .ex_branch(ex_branch),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .hazard_stall(hazard_stall),
    .stall_count(stall_count), .flush_count(flush_count));

  id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .flush(flush), .hold(hold),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_d1), .ex_rs2_data(s_d2),
    .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct3(s_f3),
    .ex_funct7(s_f7), .ex_opcode(s_op), .ex_branch(s_branch),
    .ex_mem_to_reg(s_m2r), .ex_mem_write(s_mw), .ex_alu_src(s_as),
    .ex_reg_write(s_rw), .hazard_stall(s_hz),
    .stall_count(s_stall), .flush_count(s_flush));

  typedef struct {
    logic            rst, fl, ho, v;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc, imm;
    logic [4:0]      ctrl;
    logic            e_hz, e_v;
    logic [31:0]     e_instr;
    logic [XLEN-1:0] e_pc, e_imm;
    logic [4:0]      e_ctrl;
    logic [31:0]     e_stall, e_flush;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic fl, logic ho, logic v, logic [31:0] instr,
                              logic [XLEN-1:0] pc, logic [XLEN-1:0] imm, logic [4:0] ctrl,
                              logic e_hz, logic e_v, logic [31:0] e_instr,
                              logic [XLEN-1:0] e_pc, logic [XLEN-1:0] e_imm,
                              logic [4:0] e_ctrl, logic [31:0] e_stall, logic [31:0] e_flush);
    vec_t r;
    r.rst = rst; r.fl = fl; r.ho = ho; r.v = v; r.instr = instr; r.pc = pc; r.imm = imm;
    r.ctrl = ctrl; r.e_hz = e_hz; r.e_v = e_v; r.e_instr = e_instr; r.e_pc = e_pc;
    r.e_imm = e_imm; r.e_ctrl = e_ctrl; r.e_stall = e_stall; r.e_flush = e_flush;
    return r;
  endfunction

  // Register data is tagged with the PC so each payload is distinguishable.
  function automatic logic [XLEN-1:0] d1(logic [XLEN-1:0] pc);
    return {32'h1111_1111, pc[31:0]};
  endfunction
  function automatic logic [XLEN-1:0] d2(logic [XLEN-1:0] pc);
    return {32'h2222_2222, pc[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic ho, input logic v,
                       input logic [31:0] instr, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] imm, input logic [4:0] ctrl);
    reset = rst; flush = fl; hold = ho; id_valid = v; id_instruction = instr;
    id_pc = pc; id_rs1_data = d1(pc); id_rs2_data = d2(pc); id_imm = imm;
    {id_branch, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = ctrl;
  endtask

  task automatic check_ex(input int i, input vec_t e);
    string t;
    t = $sformatf("row%0d", i);
    check({t, " ex_valid"}, 64'(ex_valid), 64'(e.e_v));
    check({t, " ex_pc"}, ex_pc, e.e_pc);
    check({t, " ex_imm"}, ex_imm, e.e_imm);
    check({t, " ex_rs1_data"}, ex_rs1_data, e.e_v ? d1(e.e_pc) : 64'd0);
    check({t, " ex_rs2_data"}, ex_rs2_data, e.e_v ? d2(e.e_pc) : 64'd0);
    check({t, " ex_fields"}, 64'({ex_funct7, ex_rs2, ex_rs1, ex_funct3, ex_rd, ex_opcode}),
          64'(e.e_instr));
    check({t, " ex_ctrl"},
          64'({ex_branch, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write}), 64'(e.e_ctrl));
    check({t, " stall_count"}, 64'(stall_count), 64'(e.e_stall));
    check({t, " flush_count"}, 64'(flush_count), 64'(e.e_flush));
    check({t, " sat stall_count"}, 64'(s_stall), (e.e_stall > 3) ? 64'd3 : 64'(e.e_stall));
  endtask

  initial begin
    //           rst fl ho v  instr   pc     imm  ctrl  | hz v  e_instr e_pc   e_imm e_ctrl st fl
    vecs.push_back(mk(1, 0, 0, 1, ADDI5,  'h0ff, 7,    C_I,  0, 0, 0,      0,     0,    0,    0, 0));
    vecs.push_back(mk(1, 1, 1, 1, LD6,    'h0ee, 3,    C_LD, 0, 0, 0,      0,     0,    0,    0, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADDI5,  'h100, 7,    C_I,  0, 1, ADDI5,  'h100, 7,    C_I,  0, 0));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h104, 0,    C_LD, 0, 1, LD6,    'h104, 0,    C_LD, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADD7,   'h108, 'h55, C_R,  1, 0, 0,      0,     0,    0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADD7,   'h108, 'h55, C_R,  0, 1, ADD7,   'h108, 'h55, C_R,  1, 0));
    vecs.push_back(mk(0, 0, 0, 1, LD0,    'h10c, 0,    C_LD, 0, 1, LD0,    'h10c, 0,    C_LD, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADD700, 'h110, 0,    C_R,  0, 1, ADD700, 'h110, 0,    C_R,  1, 0));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h114, 0,    C_LD, 0, 1, LD6,    'h114, 0,    C_LD, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADDI78, 'h118, 1,    C_I,  0, 1, ADDI78, 'h118, 1,    C_I,  1, 0));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h11c, 0,    C_LD, 0, 1, LD6,    'h11c, 0,    C_LD, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, SD6,    'h120, 0,    C_ST, 1, 0, 0,      0,     0,    0,    2, 0));
    vecs.push_back(mk(0, 0, 0, 1, SD6,    'h120, 0,    C_ST, 0, 1, SD6,    'h120, 0,    C_ST, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h124, 0,    C_LD, 0, 1, LD6,    'h124, 0,    C_LD, 2, 0));
    vecs.push_back(mk(0, 1, 0, 1, ADD7,   'h128, 'h55, C_R,  0, 0, 0,      0,     0,    0,    2, 1));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h128, 0,    C_LD, 0, 1, LD6,    'h128, 0,    C_LD, 2, 1));
    vecs.push_back(mk(0, 0, 1, 1, ADD7,   'h12c, 'h55, C_R,  1, 1, LD6,    'h128, 0,    C_LD, 2, 1));
    vecs.push_back(mk(0, 1, 1, 1, ADD7,   'h12c, 'h55, C_R,  0, 0, 0,      0,     0,    0,    2, 2));
    vecs.push_back(mk(0, 0, 0, 0, ADDI5,  'h130, 7,    C_I,  0, 0, 0,      0,     0,    0,    2, 2));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h134, 0,    C_LD, 0, 1, LD6,    'h134, 0,    C_LD, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, ADD7,   'h138, 'h55, C_R,  0, 0, 0,      0,     0,    0,    2, 2));
    vecs.push_back(mk(0, 0, 0, 1, LD6,    'h13c, 0,    C_LD, 0, 1, LD6,    'h13c, 0,    C_LD, 2, 2));
    vecs.push_back(mk(1, 0, 0, 1, ADD7,   'h140, 'h55, C_R,  0, 0, 0,      0,     0,    0,    0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].ho, vecs[i].v, vecs[i].instr,
            vecs[i].pc, vecs[i].imm, vecs[i].ctrl);
      #2;
      check($sformatf("row%0d hazard_stall", i), 64'(hazard_stall), 64'(vecs[i].e_hz));
      @(posedge clk); #1;
      check_ex(i, vecs[i]);
    end

    // Hold for 3 cycles while ID changes underneath: EX must stay frozen.
    drive(0, 0, 0, 1, ADDI5, 'h200, 7, C_I);
    @(posedge clk); #1;
    check("hold preload ex_pc", ex_pc, 64'h200);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, (k == 1) ? LD6 : ADD7, 64'h300 + 64'(k * 4), 64'(k), C_LD);
      #2;
      check($sformatf("hold%0d hazard_stall", k), 64'(hazard_stall), 64'd1);
      @(posedge clk); #1;
      check($sformatf("hold%0d ex_pc", k), ex_pc, 64'h200);
      check($sformatf("hold%0d ex_rd/op", k), 64'({ex_rd, ex_opcode}), 64'({5'd5, 7'h13}));
      check($sformatf("hold%0d ex_rs1_data", k), ex_rs1_data, d1(64'h200));
    end

    // Four load-use events: wide counter reaches 4, narrow counter sticks at 3.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, LD6, 64'h400 + 64'(k * 8), 0, C_LD);
      @(posedge clk); #1;
      drive(0, 0, 0, 1, ADD7, 64'h404 + 64'(k * 8), 0, C_R);
      #2;
      check($sformatf("sat%0d hazard_stall", k), 64'(hazard_stall), 64'd1);
      @(posedge clk); #1;
      check($sformatf("sat%0d bubble", k), 64'(ex_valid), 64'd0);
      @(posedge clk); #1;
    end
    check("sat wide stall_count", 64'(stall_count), 64'd4);
    check("sat narrow stall_count", 64'(s_stall), 64'd3);
    check("sat narrow ex_rd", 64'(s_rd), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
